dsm_input_interp: RTL and testbench

DSM_INPUT_INTERP -- requirements
Module: dsm_input_interp

---
 rtl/dsm_input_interp.sv | 156 +++++++++++++++
 tb/tb_dsm_input_interp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_input_interp.sv
// dsm_input_interp: buffers 16-bit PCM samples and upsamples them by N = 2^OSR_LOG2 into the
// 20-bit modulator input format, one vin value per modulator clock.
// Build option: define DSM_INPUT_INTERP_LINEAR_EN for a linear ramp between samples; without it
// each sample is held for N cycles (zero-order hold). FSM, handshake and flag timing are the
// same in both builds.
module dsm_input_interp #(
    parameter int unsigned OSR_LOG2   = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [19:0] vin,
    output logic        seg_start,
    output logic        underrun,
    input  logic        clear_underrun
);

    localparam int unsigned AccW = 20 + OSR_LOG2;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [OSR_LOG2-1:0] CntLast = {OSR_LOG2{1'b1}};
    localparam logic [OSR_LOG2-1:0] CntOne  = 1;
    localparam logic [PtrW:0]       PtrOne  = 1;

    typedef enum logic [1:0] {StIdle, StRun, StStarved} state_e;

    // Sample FIFO: extra pointer bit distinguishes full from empty.
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    // Datapath state.
    state_e              state_q;
    logic [19:0]         cur_q;
    logic signed [20:0]  diff_q;
    logic [AccW-1:0]     acc_q;
    logic [OSR_LOG2-1:0] cnt_q;
    logic                seg_start_q;
    logic                underrun_q;

    logic [19:0]     s_ext;
    logic [AccW-1:0] cur_shift, diff_ext;
    logic [AccW-1:0] first_acc, pop_acc;
    logic [20:0]     first_diff, pop_diff;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // Ready is forced low while reset is held so nothing is accepted into a clearing FIFO.
    assign s_ready = !full && !reset;
    assign push    = s_valid && s_ready;
    assign head    = mem_q[rd_ptr_q[PtrW-1:0]];

    // The FSM consumes a sample whenever it sits at a segment boundary and one is waiting.
    assign pop = !empty && ((state_q == StIdle) || (state_q == StStarved) ||
                            ((state_q == StRun) && (cnt_q == CntLast)));

    assign s_ext     = {{4{head[15]}}, head};
    assign cur_shift = {cur_q, {OSR_LOG2{1'b0}}};
    assign diff_ext  = AccW'(diff_q);

`ifdef DSM_INPUT_INTERP_LINEAR_EN
    // Ramp from the previous target; in STARVED acc already equals cur_shift, so this holds it.
    assign first_acc  = '0;
    assign pop_acc    = cur_shift;
    assign first_diff = {s_ext[19], s_ext};
    assign pop_diff   = {s_ext[19], s_ext} - {cur_q[19], cur_q};
`else
    // Zero-order hold: jump straight to the new sample and never step.
    assign first_acc  = {s_ext, {OSR_LOG2{1'b0}}};
    assign pop_acc    = {s_ext, {OSR_LOG2{1'b0}}};
    assign first_diff = '0;
    assign pop_diff   = '0;
`endif

    // Sample storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= s_data;
        end
    end

    // FIFO pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Interpolator FSM with registered vin source, segment pulse and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            diff_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            seg_start_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            seg_start_q <= 1'b0;
            // A set later in this block overrides the clear.
            if (clear_underrun) underrun_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        cur_q   <= s_ext;
                        diff_q  <= first_diff;
                        acc_q   <= first_acc;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (cnt_q != CntLast) begin
                        acc_q       <= acc_q + diff_ext;
                        cnt_q       <= cnt_q + CntOne;
                        seg_start_q <= (cnt_q == '0);
                    end else if (!empty) begin
                        // Land exactly on the target, then start the next segment.
                        acc_q  <= pop_acc;
                        cur_q  <= s_ext;
                        diff_q <= pop_diff;
                        cnt_q  <= '0;
                    end else begin
                        acc_q      <= cur_shift;
                        underrun_q <= 1'b1;
                        state_q    <= StStarved;
                    end
                end
                StStarved: begin
                    if (!empty) begin
                        acc_q   <= pop_acc;
                        cur_q   <= s_ext;
                        diff_q  <= pop_diff;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vin       = acc_q[AccW-1:OSR_LOG2];
    assign seg_start = seg_start_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_dsm_input_interp.sv
// Testbench for dsm_input_interp (OSR_LOG2 = 2, FIFO_DEPTH = 4). Follows the
// DSM_INPUT_INTERP_LINEAR_EN build option of the design it is compiled with.
module tb_dsm_input_interp;

    localparam int unsigned OSR_LOG2 = 2;
    localparam int          N        = 4;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        clear_underrun = 1'b0;
    logic        s_ready, seg_start, underrun;
    logic [19:0] vin;

    dsm_input_interp #(
        .OSR_LOG2   (OSR_LOG2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .vin            (vin),
        .seg_start      (seg_start),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a segment goes from prev to tgt; k steps of it have been shown.
    typedef enum {PhIdle, PhRamp, PhHold} phase_e;
    phase_e ph = PhIdle;
    int     k = 0, prev = 0, tgt = 0;
    bit     m_seg = 1'b0, m_uf = 1'b0;
    int     q[$];
    bit     chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_vin();
        int v;
        if (ph == PhIdle) begin
            v = 0;
        end else begin
`ifdef DSM_INPUT_INTERP_LINEAR_EN
            v = (prev * N + k * (tgt - prev)) >>> OSR_LOG2;
`else
            v = tgt;
`endif
        end
        return v & 32'h000F_FFFF;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit rdy, push, avail, set_u;
        int s;
        rdy   = !reset && (q.size() < DEPTH);
        push  = s_valid && rdy;
        s     = int'($signed(s_data));
        set_u = 1'b0;
        m_seg = 1'b0;
        if (reset) begin
            q.delete();
            ph   = PhIdle;
            k    = 0;
            prev = 0;
            tgt  = 0;
            m_uf = 1'b0;
        end else begin
            avail = (q.size() > 0);
            case (ph)
                PhIdle: if (avail) begin
                    prev = 0;
                    tgt  = q.pop_front();
                    k    = 0;
                    ph   = PhRamp;
                end
                PhRamp: begin
                    if (k < N - 1) begin
                        m_seg = (k == 0);
                        k++;
                    end else if (avail) begin
                        prev = tgt;
                        tgt  = q.pop_front();
                        k    = 0;
                    end else begin
                        k     = N;
                        ph    = PhHold;
                        set_u = 1'b1;
                    end
                end
                PhHold: if (avail) begin
                    prev = tgt;
                    tgt  = q.pop_front();
                    k    = 0;
                    ph   = PhRamp;
                end
                default: ph = PhIdle;
            endcase
            if (set_u) m_uf = 1'b1;
            else if (clear_underrun) m_uf = 1'b0;
            if (push) q.push_back(s);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("vin", int'(vin), model_vin());
            check("seg_start", int'(seg_start), int'(m_seg));
            check("underrun", int'(underrun), int'(m_uf));
            check("s_ready", int'(s_ready), int'(!reset && (q.size() < DEPTH)));
        end
    end

    int exp_vin[6];
    bit saw_low;
    int rate;
    int r;

    initial begin
        // Reset state.
        cycle();
        chk_en = 1'b1;
        cycle();
        check("rst_vin", int'(vin), 0);
        check("rst_ready", int'(s_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_seg", int'(seg_start), 0);
        reset = 1'b0;
        cycle();
        check("ready_after_rst", int'(s_ready), 1);

        // Two back-to-back samples from IDLE.
        s_data = 16'h0100;
        s_valid = 1'b1;
        cycle();
        s_data = 16'h0200;
        cycle();
        s_valid = 1'b0;
`ifdef DSM_INPUT_INTERP_LINEAR_EN
        exp_vin = '{32'h0, 32'h40, 32'h80, 32'hC0, 32'h100, 32'h140};
`else
        exp_vin = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h200};
`endif
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq_vin%0d", i), int'(vin), exp_vin[i]);
            check($sformatf("seq_seg%0d", i), int'(seg_start), int'(i == 1 || i == 5));
            cycle();
        end

        // Starve: hold last target and flag underrun, then clear it.
        repeat (6) cycle();
        check("starved_vin", int'(vin), 32'h200);
        check("starved_flag", int'(underrun), 1);
        clear_underrun = 1'b1;
        cycle();
        clear_underrun = 1'b0;
        check("cleared_flag", int'(underrun), 0);

        // Most negative sample ends exactly on its sign-extended value.
        s_data = 16'h8000;
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        repeat (8) cycle();
        check("neg_full_scale", int'(vin), 32'hF8000);

        // Reset in the middle of a ramp.
        s_data = 16'h0400;
        s_valid = 1'b1;
        cycle();
        s_data = 16'h7FFF;
        cycle();
        s_valid = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("midrst_vin", int'(vin), 0);
        check("midrst_ready", int'(s_ready), 0);
        check("midrst_underrun", int'(underrun), 0);
        reset = 1'b0;
        cycle();
        check("postrst_ready", int'(s_ready), 1);
        repeat (3) cycle();
        check("postrst_idle_vin", int'(vin), 0);

        // Backpressure: continuous valid for 10 cycles.
        saw_low = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 16'(16'h0111 * (i + 1));
            if (!s_ready) saw_low = 1'b1;
            cycle();
        end
        s_valid = 1'b0;
        check("backpressure_seen", int'(saw_low), 1);
        repeat (40) cycle();

        // Randomized traffic with varying load, clears and rare resets.
        for (int blk = 0; blk < 6; blk++) begin
            rate = int'($urandom_range(1, 4));
            for (int i = 0; i < 500; i++) begin
                r = int'($urandom_range(0, 7));
                s_data = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
                s_valid = (int'($urandom_range(0, 3)) < rate);
                clear_underrun = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 499) == 0);
                cycle();
            end
        end
        s_valid = 1'b0;
        clear_underrun = 1'b0;
        reset = 1'b0;
        repeat (40) cycle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
